// File: rtl/kbd_pkg.sv
// Shared constants and types for the PS/2 keyboard bus responder.
// Optional build macro: KBD_PARITY_CHECK_EN (enables odd-parity checking and the perr flag).
package kbd_pkg;

  localparam logic [3:0] KBD_ID         = 4'h5;
  localparam logic [3:0] KBD_DATA_OFF   = 4'h0;
  localparam logic [3:0] KBD_STATUS_OFF = 4'h4;

  localparam int ST_NONEMPTY  = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_PERR      = 3;
  localparam int ST_COUNT_LSB = 4;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // PS/2 frames carry odd parity over the 8 data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, frame FSM and stall timeout.
// Optional build macro: KBD_PARITY_CHECK_EN (parity bit participates in frame_err).
module ps2_frame_rx
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] data_byte,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic            clk_p0, clk_p1, clk_p2;
  logic            dat_p0, dat_p1;
  logic            fall;
  rx_state_t       state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic [TW-1:0]   tcnt;
  logic            frame_bad;

  // Idle-high reset values keep a reset release from looking like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      clk_p2 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= ps2_clk;
      clk_p1 <= clk_p0;
      clk_p2 <= clk_p1;
      dat_p0 <= ps2_data;
      dat_p1 <= dat_p0;
    end
  end

  assign fall = clk_p2 & ~clk_p1;

  always_ff @(posedge clk) begin
    if (fall && state == RX_DATA) begin
      shift <= {dat_p1, shift[7:1]};
    end
  end

`ifdef KBD_PARITY_CHECK_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (fall && state == RX_PARITY) begin
      par_bit <= dat_p1;
    end
  end

  assign frame_bad = ~dat_p1 | ~odd_parity_ok(shift, par_bit);
`else
  assign frame_bad = ~dat_p1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RX_IDLE;
      bit_cnt    <= '0;
      tcnt       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        case (state)
          RX_IDLE: begin
            if (!dat_p1) begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end
          end
          RX_DATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= RX_PARITY;
            end
          end
          RX_PARITY: state <= RX_STOP;
          RX_STOP: begin
            byte_valid <= 1'b1;
            frame_err  <= frame_bad;
            state      <= RX_IDLE;
          end
          default: state <= RX_IDLE;
        endcase
      end else if (state == RX_IDLE) begin
        tcnt <= '0;
      end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        // Stalled mid-frame: abandon the partial byte silently.
        state <= RX_IDLE;
        tcnt  <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

  assign data_byte = shift;

endmodule

// File: rtl/kbd_responder.sv
// Keyboard bus responder: scan-code FIFO, sticky status flags and combinational read mux.
// Optional build macro: KBD_PARITY_CHECK_EN (adds the perr flag at STATUS bit 3).
module kbd_responder
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        re,
  input  logic [3:0]  addr,
  output logic [31:0] dout,
  input  logic        ps2_clk,
  input  logic        ps2_data
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic          byte_valid;
  logic          frame_err;
  logic [7:0]    rx_byte;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic          perr_bit;
  logic          nonempty, full;
  logic          rd_data, rd_status;
  logic          pop, push_req, push, drop;
  logic [3:0]    count_lo;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .data_byte (rx_byte),
    .frame_err (frame_err)
  );

  assign nonempty  = (count != '0);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign rd_data   = sel & re & (addr == KBD_DATA_OFF);
  assign rd_status = sel & re & (addr == KBD_STATUS_OFF);

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign pop      = rd_data & nonempty;
  assign push_req = byte_valid & ~frame_err;
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rx_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (drop) begin
        overflow <= 1'b1;
      end else if (rd_status) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef KBD_PARITY_CHECK_EN
  logic perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr <= 1'b0;
    end else if (byte_valid && frame_err) begin
      perr <= 1'b1;
    end else if (rd_status) begin
      perr <= 1'b0;
    end
  end

  assign perr_bit = perr;
`else
  assign perr_bit = 1'b0;
`endif

  assign count_lo = 4'(count);

  always_comb begin
    dout = '0;
    if (sel) begin
      case (addr)
        KBD_DATA_OFF: begin
          if (nonempty) begin
            dout = {23'b0, 1'b1, mem[rd_ptr]};
          end
        end
        KBD_STATUS_OFF: begin
          dout[ST_COUNT_LSB +: 4] = count_lo;
          dout[ST_PERR]           = perr_bit;
          dout[ST_OVERFLOW]       = overflow;
          dout[ST_FULL]           = full;
          dout[ST_NONEMPTY]       = nonempty;
        end
        default: dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_responder.sv
// Randomised self-checking bench for kbd_responder against a queue-based model.
// Honours KBD_PARITY_CHECK_EN when the build defines it.
module tb_kbd_responder;

  localparam int DEPTH = 8;
  localparam int TO    = 300;
`ifdef KBD_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        re;
  logic [3:0]  addr;
  logic [31:0] dout;
  logic        ps2_clk;
  logic        ps2_data;

  int checks;
  int errors;

  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_perr;

  kbd_responder #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sel     (sel),
    .re      (re),
    .addr    (addr),
    .dout    (dout),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic void model_frame(input logic [7:0] b, input logic par, input logic stop);
    bit par_ok;
    bit good;
    par_ok = (^{b, par}) == 1'b1;
    good   = stop && (par_ok || !PARITY_EN);
    if (good) begin
      if (q.size() == DEPTH) m_ovf = 1'b1;
      else q.push_back(b);
    end else if (PARITY_EN) begin
      m_perr = 1'b1;
    end
  endfunction

  function automatic logic [31:0] exp_data();
    if (q.size() == 0) return 32'h0;
    return {23'b0, 1'b1, q[0]};
  endfunction

  function automatic logic [31:0] exp_status();
    logic [3:0] c;
    c = 4'(q.size());
    return {24'b0, c, m_perr, m_ovf, q.size() == DEPTH, q.size() != 0};
  endfunction

  function automatic void model_pop();
    if (q.size() != 0) void'(q.pop_front());
  endfunction

  function automatic void model_clear_flags();
    m_ovf  = 1'b0;
    m_perr = 1'b0;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_perr = 1'b0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic ps2_bit(input logic v);
    @(negedge clk) ps2_data = v;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(stop);
    repeat (8) @(negedge clk);
    ps2_data = 1'b1;
    model_frame(b, par, stop);
  endtask

  // Issues a DATA read in the cycle the stop-bit push lands.
  task automatic send_frame_pop(input logic [7:0] b, output logic [31:0] got);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b);
    @(negedge clk) ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    sel = 1'b1; re = 1'b1; addr = 4'h0;
    #1 got = dout;
    @(negedge clk) sel = 1'b0; re = 1'b0;
    repeat (6) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic bus_read(input logic [3:0] a, input logic s, output logic [31:0] d);
    @(negedge clk) sel = s; re = 1'b1; addr = a;
    #1 d = dout;
    @(negedge clk) sel = 1'b0; re = 1'b0; addr = 4'h0;
  endtask

  task automatic bus_peek(input logic [3:0] a, input logic s, output logic [31:0] d);
    @(negedge clk) sel = s; re = 1'b0; addr = a;
    #1 d = dout;
    sel = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] got;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    bus_peek(4'h4, 1'b1, got);
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected %h", got, 32'h0); end
    bus_peek(4'h0, 1'b1, got);
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected %h", got, 32'h0); end
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    bus_peek(4'h4, 1'b0, got);
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL nosel_zero: got %h expected %h", got, 32'h0); end
  endtask

  task automatic test_single();
    logic [31:0] got, exp;
    send_frame(8'h1C, 1'b0, 1'b1);
    exp = exp_data();
    bus_read(4'h0, 1'b1, got); model_pop();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL single_data: got %h expected %h", got, exp); end
    exp = exp_data();
    bus_read(4'h0, 1'b1, got); model_pop();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL single_empty: got %h expected %h", got, exp); end
    exp = exp_status();
    bus_read(4'h4, 1'b1, got); model_clear_flags();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL single_status: got %h expected %h", got, exp); end
  endtask

  task automatic test_fill_overflow();
    logic [31:0] got, exp;
    for (int i = 1; i <= 8; i++) send_frame(8'(i), ~^(8'(i)), 1'b1);
    exp = exp_status();
    bus_read(4'h4, 1'b1, got); model_clear_flags();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL full_status: got %h expected %h", got, exp); end
    send_frame(8'h09, ~^(8'h09), 1'b1);
    exp = exp_status();
    bus_read(4'h4, 1'b1, got); model_clear_flags();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL overflow_status: got %h expected %h", got, exp); end
    for (int i = 0; i < 9; i++) begin
      exp = exp_data();
      bus_read(4'h0, 1'b1, got); model_pop();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL drain_%0d: got %h expected %h", i, got, exp); end
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] got, exp;
    logic [7:0]  b;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      send_frame(b, ~^b, 1'b1);
    end
    exp = exp_data();
    send_frame_pop(8'h55, got);
    model_pop();
    model_frame(8'h55, ~^(8'h55), 1'b1);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL samecyc_pop: got %h expected %h", got, exp); end
    exp = exp_status();
    bus_read(4'h4, 1'b1, got); model_clear_flags();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL samecyc_status: got %h expected %h", got, exp); end
    for (int i = 0; i < 8; i++) begin
      exp = exp_data();
      bus_read(4'h0, 1'b1, got); model_pop();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL samecyc_drain_%0d: got %h expected %h", i, got, exp); end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] got, exp;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom));
    @(negedge clk) ps2_data = 1'b1;
    repeat (TO + 20) @(negedge clk);
    send_frame(8'hAA, ~^(8'hAA), 1'b1);
    exp = exp_status();
    bus_read(4'h4, 1'b1, got); model_clear_flags();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL timeout_status: got %h expected %h", got, exp); end
    exp = exp_data();
    bus_read(4'h0, 1'b1, got); model_pop();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL timeout_data: got %h expected %h", got, exp); end
  endtask

  task automatic test_parity();
    logic [31:0] got, exp;
    send_frame(8'h1C, 1'b1, 1'b1);
    exp = exp_status();
    bus_read(4'h4, 1'b1, got); model_clear_flags();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL parity_status: got %h expected %h", got, exp); end
    exp = exp_status();
    bus_read(4'h4, 1'b1, got); model_clear_flags();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL parity_cleared: got %h expected %h", got, exp); end
    send_frame(8'h33, ~^(8'h33), 1'b0);
    exp = exp_status();
    bus_read(4'h4, 1'b1, got); model_clear_flags();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL badstop_status: got %h expected %h", got, exp); end
    while (q.size() != 0) begin
      exp = exp_data();
      bus_read(4'h0, 1'b1, got); model_pop();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL parity_drain: got %h expected %h", got, exp); end
    end
  endtask

  task automatic test_random();
    logic [31:0] got, exp;
    logic [7:0]  b;
    int          kind, act;
    for (int n = 0; n < 16; n++) begin
      b    = 8'($urandom);
      kind = int'($urandom_range(0, 3));
      case (kind)
        2:       send_frame(b, ^b, 1'b1);
        3:       send_frame(b, ~^b, 1'b0);
        default: send_frame(b, ~^b, 1'b1);
      endcase
      act = int'($urandom_range(0, 3));
      if (act == 1) begin
        exp = exp_data();
        bus_read(4'h0, 1'b1, got); model_pop();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rand_data_%0d: got %h expected %h", n, got, exp); end
      end else if (act == 2) begin
        exp = exp_status();
        bus_read(4'h4, 1'b1, got); model_clear_flags();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rand_status_%0d: got %h expected %h", n, got, exp); end
      end else if (act == 3) begin
        bus_read(4'(($urandom_range(0, 1)) * 4), 1'b0, got);
        checks++;
        if (got !== 32'h0) begin errors++; $display("FAIL rand_nosel_%0d: got %h expected %h", n, got, 32'h0); end
      end
    end
    exp = exp_status();
    bus_read(4'h4, 1'b1, got); model_clear_flags();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL rand_final_status: got %h expected %h", got, exp); end
    while (q.size() != 0) begin
      exp = exp_data();
      bus_read(4'h0, 1'b1, got); model_pop();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL rand_drain: got %h expected %h", got, exp); end
    end
    bus_read(4'h8, 1'b1, got);
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected %h", got, 32'h0); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, exp;
    logic [7:0]  b;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      send_frame(b, ~^b, 1'b1);
    end
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clk) sel = 1'b1; re = 1'b0; addr = 4'h4;
    #2 rst_n = 1'b0;
    #1 got = dout;
    model_reset();
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL midreset_status: got %h expected %h", got, 32'h0); end
    addr = 4'h0;
    #1 got = dout;
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL midreset_data: got %h expected %h", got, 32'h0); end
    sel = 1'b0;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(8'h5A, ~^(8'h5A), 1'b1);
    exp = exp_data();
    bus_read(4'h0, 1'b1, got); model_pop();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL after_reset_data: got %h expected %h", got, exp); end
    exp = exp_status();
    bus_read(4'h4, 1'b1, got); model_clear_flags();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL after_reset_status: got %h expected %h", got, exp); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    sel      = 1'b0;
    re       = 1'b0;
    addr     = 4'h0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    model_reset();
    test_reset();
    test_single();
    test_fill_overflow();
    test_same_cycle();
    test_timeout();
    test_parity();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kbd_responder.md
Name: kbd_responder

Overview:
- Keyboard peripheral on the CPU memory bus; responds when the address decoder asserts its select for I/O region id 0x5 (addr[23:20]).
- Receives PS/2 frames from the keyboard pins, buffers scan codes in a FIFO, and returns the 32-bit read word consumed by the bus read mux.
- Bus reads are combinational (zero latency). A read of DATA pops one entry at the next clock edge.

Parameters:
- FIFO_DEPTH, 8, scan-code entries; power of 2, range 2..16.
- TIMEOUT_CYCLES, 50000, clk cycles without a PS/2 falling edge before a partial frame is abandoned.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sel  in  1  decoder select for this device
- re  in  1  CPU load strobe, valid for one cycle per load
- addr  in  4  register offset (addr[3:0]); 0x0 = DATA, 0x4 = STATUS, others read 0
- dout  out  32  read data, combinational from sel, addr and current state
- ps2_clk  in  1  PS/2 clock pin, asynchronous
- ps2_data  in  1  PS/2 data pin, asynchronous

Behaviour:
- Reset (async assert, sync release): receiver IDLE, FIFO empty (rd_ptr = wr_ptr = count = 0), overflow = 0, perr = 0, timeout counter 0. dout = 0 whenever sel = 0.
- Synchronisers: 2-FF on ps2_clk and ps2_data, plus one history FF on ps2_clk. A falling edge is registered prev = 1, cur = 0; it is detected 3 cycles after the pin edge. Data is sampled from the synchronised ps2_data in the same cycle as the edge.
- Receiver FSM, advancing only on falling edges:
  - IDLE: data = 0 -> DATA with bit_cnt = 0. data = 1 -> stay in IDLE (glitch).
  - DATA: shift in LSB first; after bit_cnt = 7 -> PARITY.
  - PARITY: latch the parity bit -> STOP.
  - STOP: frame is good if stop = 1 and the parity check passes (see optional feature). A good frame issues a push; then -> IDLE.
- Timeout: in any state other than IDLE, count cycles since the last falling edge. Reaching TIMEOUT_CYCLES -> IDLE, partial byte discarded, no push, no flag set.
- DATA read: value = {23'b0, nonempty, head_byte}; returns 0 when empty.
  - Pop when sel & re & addr == 0x0 & nonempty; effective at the next edge.
  - Reading DATA while empty is harmless: no pointer change.
- STATUS read: {24'b0, count[3:0], perr, overflow, full, nonempty}.
  - sel & re & addr == 0x4 clears overflow and perr at the next edge.
  - If a set event occurs in the same cycle as the clear, set wins.
- Push when full, without a same-cycle pop: byte dropped, overflow = 1.
- Push and pop in the same cycle:
  - When full: both happen, count unchanged, no overflow.
  - When empty: pop is ignored (nonempty = 0), push happens, count = 1.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits. full = (count == FIFO_DEPTH).
- Reset mid-frame or mid-read: everything returns to reset values immediately; the bus sees 0 or empty.
- Any re with sel = 0 has no effect.

Optional Feature:
- Macro KBD_PARITY_CHECK_EN.
- Defined: a frame is good only if the 8 data bits plus the parity bit have odd population. A bad parity drops the frame and sets perr = 1. A bad stop bit drops the frame and also sets perr.
- Undefined: the parity bit is ignored. A bad stop bit still drops the frame but sets no flag. STATUS bit 3 reads 0, and the perr register is not synthesised.

Decomposition:
- Shared package kbd_pkg:
  - register offsets KBD_DATA_OFF = 4'h0, KBD_STATUS_OFF = 4'h4
  - STATUS bit indices
  - receiver state enum rx_state_t {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP}
  - device id constant KBD_ID = 4'h5
- One sub-module: ps2_frame_rx. It owns the synchronisers, FSM and timeout, and outputs a one-cycle byte_valid plus byte and frame_err. The top level holds the FIFO, flags and read mux.

Test Plan:
- Reset, then send frame 0x1C (parity 0, stop 1) -> after STOP, DATA read = 0x0000011C; a second DATA read = 0x00000000; STATUS = 0x00.
- Send 8 frames 0x01..0x08 -> STATUS = 0x83 (count 8, full, nonempty). A 9th frame 0x09 -> STATUS = 0x87. Drain returns 0x101..0x108; the 0x09 frame is absent.
- FIFO full, push of 0x55 in the same cycle as a DATA pop -> count stays 8, overflow stays 0, last drained entry = 0x155.
- Stop ps2_clk for TIMEOUT_CYCLES after 4 data bits, then send a full frame 0xAA -> only 0x1AA is queued and STATUS has no flags set.
- With KBD_PARITY_CHECK_EN, send 0x1C with parity 1 -> no push, STATUS = 0x08. A STATUS read clears it; the next STATUS = 0x00. Without the macro, the same frame queues 0x11C.
- Assert rst_n low mid-frame with 3 entries queued -> STATUS = 0x00 immediately. A fresh frame 0x5A after release reads back 0x15A.
